softermax_drain: RTL and testbench

//  Downstream stage of the softermax row engine. Detects row completion and sweeps the engine's

---
 rtl/softermax_pkg.sv | 31 +++
 rtl/softermax_drain_fifo.sv | 68 ++++++
 rtl/softermax_drain.sv | 162 ++++++++++++++++
 tb/tb_softermax_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softermax_pkg.sv
// Shared definitions for the softermax row engine and its drain stage.
package softermax_pkg;

  // Entries per row; also the depth of the engine's probability buffer.
  localparam int SM_ROW_WIDTH  = 8;
  // Engine magnitude width; probabilities carry one extra bit.
  localparam int SM_LARGE_SIZE = 16;
  // Fractional bits dropped by the drain quantiser.
  localparam int SM_FRAC       = 4;

  // Drain FSM states.
  typedef enum logic [1:0] {
    SM_IDLE  = 2'd0,
    SM_READ  = 2'd1,
    SM_FLUSH = 2'd2
  } sm_drain_state_e;

  // Clamp a signed value into the unsigned range [0, 2^out_w - 1].
  function automatic logic [31:0] sm_saturate(input int s, input int out_w);
    int max_v;
    max_v = (1 << out_w) - 1;
    if (s < 0) begin
      return '0;
    end else if (s > max_v) begin
      return 32'(max_v);
    end else begin
      return 32'(s);
    end
  endfunction

endpackage

// File: rtl/softermax_drain_fifo.sv
// Small synchronous FIFO with occupancy count. The head entry is read straight
// from storage registers, so it is stable whenever no pop occurs.
module sm_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Next-state for storage, pointers and count; a push into a full FIFO is
  // only accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/softermax_drain.sv
// Drain stage of the softermax row engine: on row completion, sweeps the
// engine probability buffer, quantises each entry and streams it out.
//
// Output handshake: an element moves when out_valid && out_ready at a rising
// clock edge. Once out_valid is high it stays high, with out_data/out_idx/
// out_last unchanged, until that transfer happens. out_valid depends only on
// registered state, never combinationally on out_ready.
module softermax_drain
  import softermax_pkg::*;
#(
  parameter int ROW_WIDTH  = SM_ROW_WIDTH,
  parameter int IN_W       = SM_LARGE_SIZE + 1,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = SM_FRAC,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(ROW_WIDTH),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1,
  localparam int FW        = 1 + AW + OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done_in,
  output logic [AW-1:0]    rd_addr,
  input  logic [IN_W-1:0]  rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [AW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             row_done,
  output logic [1:0]       dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(ROW_WIDTH - 1);

  sm_drain_state_e state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            armed_q, armed_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   inflight_idx_q, inflight_idx_d;
  logic            busy_q, busy_d;
  logic            row_done_q, row_done_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_head;
  logic [FW-1:0]   push_word;
  logic            pop;
  logic [CW:0]     credit_used;
  logic            credit_ok;

  logic signed [IN_W-1:0] rd_s;
  logic signed [IN_W-1:0] rd_shifted;
  logic [OUT_W-1:0]       q_data;

  // Quantise the returned probability: arithmetic shift, then clamp to the
  // unsigned output range.
  always_comb begin
    rd_s       = rd_data;
    rd_shifted = rd_s >>> SHIFT;
    q_data     = OUT_W'(sm_saturate(int'(rd_shifted), OUT_W));
  end

  // A read may be issued only if the FIFO can still take it, counting the
  // element already on its way back from the engine.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    credit_ok   = credit_used < (CW + 1)'(FIFO_DEPTH);
  end

  // Drain FSM, address counter, in-flight tracking and re-arm logic.
  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    armed_d        = armed_q | ~done_in;
    inflight_d     = 1'b0;
    inflight_idx_d = inflight_idx_q;
    case (state_q)
      SM_IDLE: begin
        if (done_in && armed_q) begin
          state_d   = SM_READ;
          armed_d   = 1'b0;
          rd_addr_d = '0;
        end
      end
      SM_READ: begin
        if (credit_ok) begin
          inflight_d     = 1'b1;
          inflight_idx_d = rd_addr_q;
          if (rd_addr_q == LAST_IDX) begin
            state_d   = SM_FLUSH;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      SM_FLUSH: begin
        // Elements leave in order, so an empty FIFO with nothing in flight
        // means the last element has been accepted.
        if (fifo_empty && !inflight_q) begin
          state_d = SM_IDLE;
        end
      end
      default: state_d = SM_IDLE;
    endcase
    busy_d = (state_d != SM_IDLE);
  end

  // Output-side control: pop on transfer, pulse row_done after the last one.
  always_comb begin
    pop        = out_valid && out_ready;
    row_done_d = pop && out_last;
    push_word  = {(inflight_idx_q == LAST_IDX), inflight_idx_q, q_data};
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SM_IDLE;
      rd_addr_q      <= '0;
      armed_q        <= 1'b1;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      busy_q         <= 1'b0;
      row_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      armed_q        <= armed_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      busy_q         <= busy_d;
      row_done_q     <= row_done_d;
    end
  end

  sm_stream_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rd_addr   = rd_addr_q;
  assign out_valid = !fifo_empty;
  assign out_last  = fifo_head[FW-1];
  assign out_idx   = fifo_head[FW-2 -: AW];
  assign out_data  = fifo_head[OUT_W-1:0];
  assign busy      = busy_q;
  assign row_done  = row_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_softermax_drain.sv
// Directed bench for softermax_drain: a default instance (FIFO_DEPTH=4) and a
// second instance with FIFO_DEPTH=2, each fed by a registered engine model.
module tb_softermax_drain;

  logic        clk;
  logic        rst_n;

  logic        done_in, out_ready, out_valid, out_last, busy, row_done;
  logic [2:0]  rd_addr, out_idx;
  logic [16:0] rd_data;
  logic [7:0]  out_data;
  logic [1:0]  dbg_state;

  logic        done_in_2, out_ready_2, out_valid_2, out_last_2, busy_2, row_done_2;
  logic [2:0]  rd_addr_2, out_idx_2;
  logic [16:0] rd_data_2;
  logic [7:0]  out_data_2;
  logic [1:0]  dbg_state_2;

  logic [16:0] eng_mem [8];
  logic [11:0] exp_q [$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Clock and engine read-port model (address in t, data in t+1).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data   <= eng_mem[rd_addr];
    rd_data_2 <= eng_mem[rd_addr_2];
  end

  softermax_drain u_dut (
    .clk(clk), .rst_n(rst_n), .done_in(done_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .row_done(row_done), .dbg_state(dbg_state)
  );

  softermax_drain #(.FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .done_in(done_in_2), .rd_addr(rd_addr_2),
    .rd_data(rd_data_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
    .out_data(out_data_2), .out_idx(out_idx_2), .out_last(out_last_2),
    .busy(busy_2), .row_done(row_done_2), .dbg_state(dbg_state_2)
  );

  // Driver helpers.
  task automatic load_basic();
    for (int i = 0; i < 8; i++) eng_mem[i] = 17'((i + 1) * 16);
  endtask

  task automatic push_exp(input int idx, input logic [7:0] data);
    exp_q.push_back({(idx == 7), 3'(idx), data});
  endtask

  task automatic push_basic_row();
    for (int i = 0; i < 8; i++) push_exp(i, 8'(i + 1));
  endtask

  task automatic idle_cycles(input int n);
    done_in   = 1'b0;
    done_in_2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Consume one row from the selected instance against exp_q.
  // mode 0: always ready; 1: ready 1,0,1,0..; 2: ready 0,0,1,1,1..
  task automatic drain_row(input int which, input int mode, input int budget);
    int          cyc;
    int          step;
    logic        v, r, held_v;
    logic [11:0] got, held, exp;
    cyc = 0; step = 0; held_v = 1'b0; held = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v   = (which == 2) ? out_valid_2 : out_valid;
      got = (which == 2) ? {out_last_2, out_idx_2, out_data_2}
                         : {out_last, out_idx, out_data};
      if (held_v && v) begin
        total_cnt++;
        if (got !== held) $display("FAIL hold_stable: got %h required %h", got, held);
        else pass_cnt++;
      end
      if (which == 2) begin
        total_cnt++;
        if (int'(u_dut2.u_fifo.count_q) > 2)
          $display("FAIL fifo_count_bound: got %0d required <=2", u_dut2.u_fifo.count_q);
        else pass_cnt++;
      end
      case (mode)
        1:       r = (step % 2) == 0;
        2:       r = (step >= 2);
        default: r = 1'b1;
      endcase
      step++;
      if (which == 2) out_ready_2 = r;
      else            out_ready   = r;
      if (v && r) begin
        exp = exp_q.pop_front();
        total_cnt++;
        if (got !== exp) $display("FAIL element: got {last,idx,data}=%h required %h", got, exp);
        else pass_cnt++;
        held_v = 1'b0;
      end else begin
        held_v = v;
        held   = got;
      end
    end
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d elements missing, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    total_cnt++;
    if (((which == 2) ? row_done_2 : row_done) !== 1'b1)
      $display("FAIL row_done_pulse: got %b required 1", (which == 2) ? row_done_2 : row_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({((which == 2) ? row_done_2 : row_done), ((which == 2) ? busy_2 : busy)} !== 2'b00)
      $display("FAIL row_done_end: got row_done,busy=%b%b required 00",
               (which == 2) ? row_done_2 : row_done, (which == 2) ? busy_2 : busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; done_in = 1'b0; done_in_2 = 1'b0;
    out_ready = 1'b0; out_ready_2 = 1'b0;
    load_basic();
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, row_done, rd_addr, out_data, out_idx, out_last, dbg_state} !== 18'd0)
      $display("FAIL reset_state: got v=%b busy=%b rd=%b addr=%0d data=%0d idx=%0d last=%b st=%0d required all 0",
               out_valid, busy, row_done, rd_addr, out_data, out_idx, out_last, dbg_state);
    else pass_cnt++;
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    load_basic();
    push_basic_row();
    done_in = 1'b1;
    drain_row(1, 0, 60);
    idle_cycles(2);
  endtask

  task automatic test_saturation();
    eng_mem[0] = 17'h1FFF0; eng_mem[1] = 17'h00FF0;
    eng_mem[2] = 17'h00FFF; eng_mem[3] = 17'h00005;
    eng_mem[4] = 17'h01000; eng_mem[5] = 17'h0F000;
    eng_mem[6] = 17'h10000; eng_mem[7] = 17'h00FE0;
    push_exp(0, 8'd0);   push_exp(1, 8'd255);
    push_exp(2, 8'd255); push_exp(3, 8'd0);
    push_exp(4, 8'd255); push_exp(5, 8'd255);
    push_exp(6, 8'd0);   push_exp(7, 8'd254);
    done_in = 1'b1;
    drain_row(1, 0, 60);
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    load_basic();
    out_ready = 1'b0;
    done_in   = 1'b1;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (rd_addr !== 3'd4 || u_dut.u_fifo.count_q !== 3'd4)
      $display("FAIL bp_stall: got rd_addr=%0d count=%0d required 4/4", rd_addr, u_dut.u_fifo.count_q);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid, out_last, out_idx, out_data} !== {1'b1, 1'b0, 3'd0, 8'd1})
      $display("FAIL bp_head: got v=%b idx=%0d data=%0d required v=1 idx=0 data=1",
               out_valid, out_idx, out_data);
    else pass_cnt++;
    push_basic_row();
    drain_row(1, 1, 80);
    idle_cycles(2);
  endtask

  task automatic test_sticky_done();
    int extra;
    load_basic();
    push_basic_row();
    done_in = 1'b1;
    drain_row(1, 0, 60);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL sticky_retrigger: got %0d active cycles required 0", extra);
    else pass_cnt++;
    done_in = 1'b0;
    @(negedge clk);
    done_in = 1'b1;
    push_basic_row();
    drain_row(1, 0, 60);
  endtask

  task automatic test_reset_mid_drain();
    bit found;
    found = 1'b0;
    done_in = 1'b0;
    @(negedge clk);
    done_in   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd3) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL mid_reset_wait: got no idx 3 required idx 3 transfer");
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, busy, row_done, rd_addr, out_data, out_idx, out_last} !== 16'd0)
      $display("FAIL mid_reset_state: got v=%b busy=%b addr=%0d data=%0d idx=%0d required all 0",
               out_valid, busy, rd_addr, out_data, out_idx);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_basic_row();
    drain_row(1, 0, 60);
    idle_cycles(2);
  endtask

  task automatic test_full_fifo();
    load_basic();
    out_ready_2 = 1'b0;
    done_in_2   = 1'b1;
    push_basic_row();
    drain_row(2, 2, 80);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_sticky_done();
    test_reset_mid_drain();
    test_full_fifo();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
